// File: rtl/arbitro_rr_if.sv
// Handshake bundle for arbitro_rr: input-FIFO read side, output-FIFO write side and grant index.
interface arbitro_rr_if #(
    parameter int BW = 12
);
    logic [3:0]    emptyFIFO;
    logic [BW-1:0] data0;
    logic [BW-1:0] data1;
    logic [BW-1:0] data2;
    logic [BW-1:0] data3;
    logic          almost_full;
    logic [3:0]    pop;
    logic          push;
    logic [BW-1:0] dataout;
    logic [1:0]    grant;

    modport master (
        input  emptyFIFO, data0, data1, data2, data3, almost_full,
        output pop, push, dataout, grant
    );

    modport slave (
        output emptyFIFO, data0, data1, data2, data3, almost_full,
        input  pop, push, dataout, grant
    );
endinterface

// File: rtl/arbitro_rr.sv
// Four-input FIFO arbiter feeding one output FIFO; round-robin with per-grant burst limit.
// Define FIXED_PRIORITY_EN for fixed priority (port 0 highest) instead of round-robin.
module arbitro_rr #(
    parameter int BW    = 12,
    parameter int BURST = 4
) (
    input  logic         clk,
    input  logic         reset,
    arbitro_rr_if.master bus
);
    typedef enum logic [1:0] {IDLE, SERVE, STALL} state_t;

    state_t        state;
    logic [1:0]    grant_r;
    logic [1:0]    last_r;
    logic [4:0]    cnt_r;
    logic [1:0]    grant_d;
    logic          push_r;
    logic [BW-1:0] dout_hold;
    logic [BW-1:0] data_sel;
    logic          pop_any;
    logic          all_empty;

    // First non-empty port searching base+1, base+2, ... base+4 (wrapping to base itself).
    function automatic logic [1:0] next_port(input logic [1:0] base, input logic [3:0] empty);
        logic [1:0] idx;
        next_port = base;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (!empty[idx]) next_port = idx;
        end
    endfunction

    assign all_empty = &bus.emptyFIFO;
    assign pop_any   = (state == SERVE) && !reset && !bus.emptyFIFO[grant_r] && !bus.almost_full;

    always_comb begin
        case (grant_d)
            2'd0:    data_sel = bus.data0;
            2'd1:    data_sel = bus.data1;
            2'd2:    data_sel = bus.data2;
            default: data_sel = bus.data3;
        endcase
    end

    // Reset squashes everything visible immediately, including a push already queued by a pop.
    assign bus.pop     = pop_any ? (4'b0001 << grant_r) : 4'b0000;
    assign bus.push    = push_r && !reset;
    assign bus.dataout = reset ? '0 : (push_r ? data_sel : dout_hold);
    assign bus.grant   = reset ? 2'd0 : grant_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_r   <= 2'd0;
            last_r    <= 2'd3;
            cnt_r     <= 5'd0;
            grant_d   <= 2'd0;
            push_r    <= 1'b0;
            dout_hold <= '0;
        end else begin
            push_r <= pop_any;
            if (pop_any) grant_d <= grant_r;
            if (push_r) dout_hold <= data_sel;
`ifdef FIXED_PRIORITY_EN
            if (!all_empty) grant_r <= next_port(2'd3, bus.emptyFIFO);
            case (state)
                IDLE:    if (!all_empty) state <= SERVE;
                SERVE: begin
                    if (all_empty) state <= IDLE;
                    else if (bus.almost_full) state <= STALL;
                end
                STALL:   if (!bus.almost_full) state <= SERVE;
                default: state <= IDLE;
            endcase
`else
            case (state)
                IDLE: begin
                    if (!all_empty) begin
                        grant_r <= next_port(last_r, bus.emptyFIFO);
                        state   <= SERVE;
                    end
                end
                SERVE: begin
                    if (pop_any) begin
                        if (cnt_r + 5'd1 == 5'(BURST)) begin
                            last_r  <= grant_r;
                            cnt_r   <= 5'd0;
                            grant_r <= next_port(grant_r, bus.emptyFIFO);
                        end else begin
                            cnt_r <= cnt_r + 5'd1;
                        end
                    end else if (bus.emptyFIFO[grant_r]) begin
                        // Rotation wins over a simultaneous almost_full; the stall follows it.
                        last_r <= grant_r;
                        cnt_r  <= 5'd0;
                        if (all_empty) begin
                            state <= IDLE;
                        end else begin
                            grant_r <= next_port(grant_r, bus.emptyFIFO);
                            if (bus.almost_full) state <= STALL;
                        end
                    end else begin
                        state <= STALL;
                    end
                end
                STALL:   if (!bus.almost_full) state <= SERVE;
                default: state <= IDLE;
            endcase
`endif
        end
    end
endmodule

// File: tb/tb_arbitro_rr.sv
// Self-checking bench for arbitro_rr: FIFO environment, cycle-level behavioural model, directed scenarios.
module tb_arbitro_rr;
    localparam int BW    = 12;
    localparam int BURST = 4;
    localparam int DEPTH = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    arbitro_rr_if #(.BW(BW)) bus ();

    arbitro_rr #(.BW(BW), .BURST(BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [BW-1:0] mem [4][DEPTH];
    int            wr_ptr [4];
    int            rd_ptr [4];
    logic [BW-1:0] rd_data [4];
    logic [3:0]    dut_pop;

    int            errors;
    int            checks;

    int            m_mode;
    int            m_grant;
    int            m_last;
    int            m_count;
    bit            m_pend;
    logic [BW-1:0] m_pend_word;
    logic [BW-1:0] m_hold;

    logic [3:0]    pop_log [$];
    logic          push_log [$];
    logic [BW-1:0] data_log [$];
    logic [1:0]    grant_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    function automatic int first_ready(input int start);
        for (int k = 0; k < 4; k++)
            if (bus.emptyFIFO[(start + k) % 4] == 1'b0) return (start + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] exp_pop();
        if (reset || m_mode != 1 || bus.almost_full || bus.emptyFIFO[m_grant]) return 4'b0000;
        return 4'b0001 << m_grant;
    endfunction

    task automatic loadWords(input int port, input int n, input logic [BW-1:0] base);
        for (int k = 0; k < n; k++) begin
            mem[port][wr_ptr[port]] = base + BW'(k);
            wr_ptr[port]++;
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < 4; i++) bus.emptyFIFO[i] = (wr_ptr[i] == rd_ptr[i]);
        bus.data0 = rd_data[0];
        bus.data1 = rd_data[1];
        bus.data2 = rd_data[2];
        bus.data3 = rd_data[3];
    endtask

    task automatic envPop(input logic [3:0] p);
        for (int i = 0; i < 4; i++) begin
            if (p[i] && wr_ptr[i] != rd_ptr[i]) begin
                rd_data[i] = mem[i][rd_ptr[i]];
                rd_ptr[i]++;
            end
        end
    endtask

    // Expected outputs for the current cycle come from the model's view of who is granted and what is in flight.
    task automatic checkOutput();
        logic [3:0]    ep;
        logic          epush;
        logic [BW-1:0] ed;
        logic [1:0]    eg;
        ep    = exp_pop();
        epush = m_pend && !reset;
        ed    = reset ? '0 : (m_pend ? m_pend_word : m_hold);
        eg    = reset ? 2'd0 : 2'(m_grant);
        check("pop", bus.pop, ep);
        check("push", bus.push, epush);
        check("dataout", bus.dataout, ed);
        check("grant", bus.grant, eg);
        dut_pop = bus.pop;
        pop_log.push_back(bus.pop);
        push_log.push_back(bus.push);
        data_log.push_back(bus.dataout);
        grant_log.push_back(bus.grant);
    endtask

    task automatic modelStep();
        logic [3:0] p;
        int         nxt;
        p = exp_pop();
        if (reset) begin
            m_mode = 0; m_grant = 0; m_last = 3; m_count = 0; m_pend = 0; m_hold = '0;
            return;
        end
        if (m_pend) m_hold = m_pend_word;
        m_pend = (p != 4'b0000);
        if (m_pend) m_pend_word = mem[m_grant][rd_ptr[m_grant]];
`ifdef FIXED_PRIORITY_EN
        nxt = first_ready(0);
        if (nxt >= 0) m_grant = nxt;
        case (m_mode)
            0: if (nxt >= 0) m_mode = 1;
            1: begin
                if (nxt < 0) m_mode = 0;
                else if (bus.almost_full) m_mode = 2;
            end
            default: if (!bus.almost_full) m_mode = 1;
        endcase
`else
        case (m_mode)
            0: begin
                nxt = first_ready(m_last + 1);
                if (nxt >= 0) begin m_grant = nxt; m_mode = 1; end
            end
            1: begin
                if (p != 4'b0000) begin
                    m_count++;
                    if (m_count == BURST) begin
                        m_last = m_grant; m_count = 0; m_grant = first_ready(m_grant + 1);
                    end
                end else if (bus.emptyFIFO[m_grant]) begin
                    m_last = m_grant; m_count = 0;
                    nxt = first_ready(m_grant + 1);
                    if (nxt < 0) m_mode = 0;
                    else begin
                        m_grant = nxt;
                        if (bus.almost_full) m_mode = 2;
                    end
                end else begin
                    m_mode = 2;
                end
            end
            default: if (!bus.almost_full) m_mode = 1;
        endcase
`endif
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            checkOutput();
            @(posedge clk);
            modelStep();
            #1;
            envPop(dut_pop);
            applyStimulus();
        end
    endtask

    task automatic startScenario(input string name);
        $display("[TB] scenario: %s", name);
        reset = 1'b1;
        runCycles(2);
        pop_log.delete();
        push_log.delete();
        data_log.delete();
        grant_log.delete();
    endtask

    function automatic int port_of(input logic [3:0] p);
        case (p)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    initial begin
        int first_idx;
        int last_idx;
        int n_pops;
        int exp_seq [24];
        logic [3:0] exp_p29 [10];
        logic       exp_u29 [10];

        errors = 0;
        checks = 0;
        for (int i = 0; i < 4; i++) begin
            wr_ptr[i] = 0; rd_ptr[i] = 0; rd_data[i] = '0;
        end
        m_mode = 0; m_grant = 0; m_last = 3; m_count = 0; m_pend = 0; m_pend_word = '0; m_hold = '0;
        dut_pop = 4'b0000;
        bus.almost_full = 1'b0;
        reset = 1'b1;
        applyStimulus();

        // Reset with everything empty: all outputs quiet.
        startScenario("reset idle");
        runCycles(2);
        check("r026_pop", pop_log[1], 4'b0000);
        check("r026_push", push_log[1], 1'b0);
        check("r026_dataout", data_log[1], 12'h000);
        check("r026_grant", grant_log[1], 2'd0);

        // Only FIFO 2 holds three words.
        startScenario("single port");
        loadWords(2, 3, 12'h8D1);
        applyStimulus();
        reset = 1'b0;
        runCycles(8);
        check("r027_pop_c0", pop_log[0], 4'b0000);
        for (int c = 1; c <= 3; c++) check("r027_pop", pop_log[c], 4'b0100);
        check("r027_pop_c4", pop_log[4], 4'b0000);
        check("r027_push_c1", push_log[1], 1'b0);
        for (int c = 2; c <= 4; c++) begin
            check("r027_push", push_log[c], 1'b1);
            check("r027_word", data_log[c], 12'h8D1 + 12'(c - 2));
        end
        check("r027_push_c5", push_log[5], 1'b0);
        check("r027_hold", data_log[6], 12'h8D3);

`ifndef FIXED_PRIORITY_EN
        // All four FIFOs with six words: bursts of 4 then 2 in port order.
        startScenario("four ports burst");
        for (int p = 0; p < 4; p++) loadWords(p, 6, 12'(256 * (p + 1)));
        applyStimulus();
        reset = 1'b0;
        runCycles(32);
        exp_seq = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,0,1,1,2,2,3,3};
        n_pops = 0;
        first_idx = -1;
        last_idx = -1;
        foreach (pop_log[c]) begin
            if (pop_log[c] != 4'b0000) begin
                if (n_pops < 24) check("r028_port", port_of(pop_log[c]), exp_seq[n_pops]);
                if (n_pops == 0) first_idx = c;
                if (n_pops == 15) last_idx = c;
                n_pops++;
            end
        end
        check("r028_pop_count", n_pops, 24);
        check("r028_no_gap_first16", last_idx - first_idx, 15);

        // almost_full during the port 1 burst after two pops.
        startScenario("stall in burst");
        loadWords(1, 6, 12'h510);
        loadWords(3, 2, 12'h730);
        applyStimulus();
        reset = 1'b0;
        runCycles(3);
        bus.almost_full = 1'b1;
        runCycles(3);
        bus.almost_full = 1'b0;
        runCycles(12);
        exp_p29 = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b1000};
        exp_u29 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int c = 0; c < 10; c++) begin
            check("r029_pop", pop_log[c], exp_p29[c]);
            check("r029_push", push_log[c], exp_u29[c]);
        end
        for (int c = 3; c <= 6; c++) check("r029_grant_held", grant_log[c], 2'd1);

        // Reset one cycle after a pop on port 2.
        startScenario("reset after pop");
        loadWords(2, 3, 12'hA20);
        applyStimulus();
        reset = 1'b0;
        runCycles(2);
        reset = 1'b1;
        loadWords(0, 2, 12'h0C0);
        applyStimulus();
        runCycles(2);
        reset = 1'b0;
        runCycles(12);
        check("r030_pop_before", pop_log[1], 4'b0100);
        check("r030_grant_before", grant_log[1], 2'd2);
        check("r030_push_squashed", push_log[2], 1'b0);
        check("r030_grant_reset", grant_log[2], 2'd0);
        check("r030_push_after_release", push_log[4], 1'b0);
        check("r030_pop_idle", pop_log[4], 4'b0000);
        check("r030_first_pop_port0", pop_log[5], 4'b0001);
        check("r030_first_word", data_log[6], 12'h0C0);
`else
        // Fixed priority: FIFO 0 drains completely before FIFO 3 is touched.
        startScenario("fixed priority");
        loadWords(0, 3, 12'h101);
        loadWords(3, 2, 12'h301);
        applyStimulus();
        reset = 1'b0;
        runCycles(12);
        n_pops = 0;
        first_idx = 0;
        foreach (pop_log[c]) begin
            if (pop_log[c] == 4'b0001) n_pops++;
            if (pop_log[c] == 4'b1000 && n_pops < 3) first_idx = 1;
        end
        check("r031_order", first_idx, 0);
        check("r031_port0_pops", n_pops, 3);
`endif

        reset = 1'b1;
        runCycles(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
